// File: rtl/direct_sound_fifo.sv
// One Direct Sound channel FIFO: packs 32-bit writes into word storage and
// plays them out one signed PCM byte per timer tick, little-endian.
module direct_sound_fifo #(
  parameter int unsigned DEPTH_WORDS   = 8,
  parameter int unsigned DMA_THRESHOLD = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           fifo_clear,
  input  logic                           write_en,
  input  logic [1:0]                     write_strb,
  input  logic [31:0]                    write_data,
  input  logic                           timer_tick,
  output logic [7:0]                     sample,
  output logic                           sample_valid,
  output logic [$clog2(DEPTH_WORDS):0]   level,
  output logic                           dma_req,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned PW = $clog2(DEPTH_WORDS);
  localparam int unsigned LW = PW + 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [15:0]   staging;
  logic [31:0]   cur_word;
  logic [1:0]    byte_idx;
  logic          cur_valid;

  logic [31:0]   head;
  logic [31:0]   push_word;
  logic          push_req;
  logic          push_acc;
  logic          fifo_nonempty;
  logic          fifo_full;
  logic          prefetch;
  logic          reload;
  logic          pop;
  logic [LW-1:0] level_nxt;

  // Push/pop decisions for this cycle; a clear suppresses both.
  always_comb begin
    head          = mem[rd_ptr];
    push_word     = write_data;
    push_req      = 1'b0;
    fifo_nonempty = (level != '0);
    fifo_full     = (level == LW'(DEPTH_WORDS));
    prefetch      = !fifo_clear && !cur_valid && fifo_nonempty;
    reload        = !fifo_clear && timer_tick && cur_valid &&
                    (byte_idx == 2'd3) && fifo_nonempty;
    pop           = prefetch || reload;
    if (write_en && !fifo_clear) begin
      if (write_strb == 2'b11) begin
        push_req = 1'b1;
      end else if (write_strb == 2'b10) begin
        push_req  = 1'b1;
        push_word = {write_data[31:16], staging};
      end
    end
    push_acc  = push_req && (!fifo_full || pop);
    level_nxt = level + LW'(push_acc) - LW'(pop);
  end

  // Word storage; pointers and level carry the reset.
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      staging      <= '0;
      cur_word     <= '0;
      byte_idx     <= '0;
      cur_valid    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      dma_req      <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (fifo_clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      staging      <= '0;
      cur_word     <= '0;
      byte_idx     <= '0;
      cur_valid    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      dma_req      <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      underflow    <= 1'b0;
      overflow     <= push_req && !push_acc;
      dma_req      <= pop && (level_nxt <= LW'(DMA_THRESHOLD));
      level        <= level_nxt;
      if (write_en && write_strb == 2'b01) begin
        staging <= write_data[15:0];
      end
      if (push_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Play the current byte; on the last byte reload from the head or go idle.
      if (timer_tick) begin
        if (cur_valid) begin
          sample       <= cur_word[{byte_idx, 3'b000} +: 8];
          sample_valid <= 1'b1;
          byte_idx     <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            if (reload) begin
              cur_word <= head;
            end else begin
              cur_valid <= 1'b0;
            end
          end
        end else begin
          underflow <= 1'b1;
        end
      end
      if (prefetch) begin
        cur_word  <= head;
        byte_idx  <= '0;
        cur_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_direct_sound_fifo.sv
// Directed bench for direct_sound_fifo with hand-computed expectations.
module tb_direct_sound_fifo;

  logic        clock;
  logic        reset;
  logic        fifo_clear;
  logic        write_en;
  logic [1:0]  write_strb;
  logic [31:0] write_data;
  logic        timer_tick;
  logic [7:0]  sample;
  logic        sample_valid;
  logic [3:0]  level;
  logic        dma_req;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  direct_sound_fifo #(.DEPTH_WORDS(8), .DMA_THRESHOLD(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .fifo_clear   (fifo_clear),
    .write_en     (write_en),
    .write_strb   (write_strb),
    .write_data   (write_data),
    .timer_tick   (timer_tick),
    .sample       (sample),
    .sample_valid (sample_valid),
    .level        (level),
    .dma_req      (dma_req),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic clr, input logic we, input logic [1:0] strb,
                     input logic [31:0] data, input logic tk);
    fifo_clear = clr;
    write_en   = we;
    write_strb = strb;
    write_data = data;
    timer_tick = tk;
    @(posedge clock);
    #1;
    fifo_clear = 1'b0;
    write_en   = 1'b0;
    write_strb = 2'b00;
    write_data = 32'h0;
    timer_tick = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] strb, input logic [31:0] data);
    cyc(1'b0, 1'b1, strb, data, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
  endtask

  task automatic clear();
    cyc(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] mk(input int i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  initial begin
    logic [7:0] exp_bytes [4];
    reset      = 1'b1;
    fifo_clear = 1'b0;
    write_en   = 1'b0;
    write_strb = 2'b00;
    write_data = 32'h0;
    timer_tick = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_pulses", {28'h0, sample_valid, dma_req, overflow, underflow}, 32'h0);
    reset = 1'b0;

    // 1: single word, little-endian playback, then underflow
    wr(2'b11, 32'h11223344);
    check("t1_level_push", 32'(level), 32'd1);
    idle();
    check("t1_level_prefetch", 32'(level), 32'd0);
    check("t1_dma_prefetch", 32'(dma_req), 32'd1);
    exp_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};
    for (int b = 0; b < 4; b++) begin
      tick();
      check($sformatf("t1_sample%0d", b), 32'(sample), 32'(exp_bytes[b]));
      check($sformatf("t1_valid%0d", b), 32'(sample_valid), 32'd1);
    end
    tick();
    check("t1_underflow", 32'(underflow), 32'd1);
    check("t1_hold_sample", 32'(sample), 32'h11);
    check("t1_no_valid", 32'(sample_valid), 32'd0);

    // 2: half-word assembly through staging
    wr(2'b01, 32'h0000AABB);
    check("t2_no_push_low", 32'(level), 32'd0);
    wr(2'b10, 32'hCCDD0000);
    check("t2_push_high", 32'(level), 32'd1);
    idle();
    exp_bytes = '{8'hBB, 8'hAA, 8'hDD, 8'hCC};
    for (int b = 0; b < 4; b++) begin
      tick();
      check($sformatf("t2_sample%0d", b), 32'(sample), 32'(exp_bytes[b]));
    end

    // 3: fill to full and overflow
    clear();
    for (int i = 1; i <= 8; i++) wr(2'b11, mk(i));
    check("t3_level_after8", 32'(level), 32'd7);
    wr(2'b11, mk(9));
    check("t3_level_after9", 32'(level), 32'd8);
    check("t3_no_overflow9", 32'(overflow), 32'd0);
    wr(2'b11, 32'hFFFF_FFFF);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_level_full", 32'(level), 32'd8);
    idle();
    check("t3_overflow_pulse", 32'(overflow), 32'd0);

    // 4: drain with dma requests at and below threshold
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t4_first_byte_w%0d", k), 32'(sample), 32'(8'(4*k)));
      tick();
      tick();
      tick();
      check($sformatf("t4_level_w%0d", k), 32'(level), 32'(8 - k));
      check($sformatf("t4_dma_w%0d", k), 32'(dma_req), (8 - k) <= 4 ? 32'd1 : 32'd0);
    end
    idle();
    check("t4_dma_pulse", 32'(dma_req), 32'd0);
    for (int i = 20; i < 23; i++) wr(2'b11, mk(i));
    check("t4_refill_level", 32'(level), 32'd6);
    repeat (4) tick();
    check("t4_level_above", 32'(level), 32'd5);
    check("t4_dma_quiet", 32'(dma_req), 32'd0);

    // 5: write on the same cycle a reload pops a full FIFO
    clear();
    for (int i = 1; i <= 9; i++) wr(2'b11, mk(i));
    check("t5_full", 32'(level), 32'd8);
    for (int b = 0; b < 3; b++) begin
      tick();
      check($sformatf("t5_w1_b%0d", b), 32'(sample), 32'(8'(4 + b)));
    end
    cyc(1'b0, 1'b1, 2'b11, mk(10), 1'b1);
    check("t5_w1_b3", 32'(sample), 32'(8'(7)));
    check("t5_level_same", 32'(level), 32'd8);
    check("t5_no_overflow", 32'(overflow), 32'd0);
    for (int j = 2; j <= 10; j++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        check($sformatf("t5_w%0d_b%0d", j, b), 32'(sample), 32'(8'(4*j + b)));
      end
    end
    check("t5_drained", 32'(level), 32'd0);

    // 6: clear mid-play beats same-cycle write and tick
    wr(2'b11, 32'h99887766);
    idle();
    tick();
    check("t6_playing", 32'(sample), 32'h66);
    cyc(1'b1, 1'b1, 2'b11, 32'h12345678, 1'b1);
    check("t6_level", 32'(level), 32'd0);
    check("t6_sample", 32'(sample), 32'h0);
    check("t6_valid", 32'(sample_valid), 32'd0);
    tick();
    check("t6_underflow", 32'(underflow), 32'd1);
    check("t6_still_zero", 32'(sample), 32'h0);
    wr(2'b11, 32'hDEADBEEF);
    idle();
    tick();
    check("t6_replay", 32'(sample), 32'hEF);
    check("t6_replay_valid", 32'(sample_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
